// File: rtl/rv64_decode_exec.sv
// RV64IM decode-and-execute stage: decoder, immediate generator, 64-bit ALU with
// M extension and branch comparator. Every output is registered once.
module rv64_decode_exec #(
  parameter int DW = 64,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [IW-1:0] inst,
  input  logic [DW-1:0] pc,
  input  logic [DW-1:0] rs1_data,
  input  logic [DW-1:0] rs2_data,
  output logic [DW-1:0] imm,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          br_taken,
  output logic          jal_en,
  output logic          jalr_en,
  output logic          wb_en,
  output logic          wb_load,
  output logic          wb_pc,
  output logic          wb_alu,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [1:0]    mem_size,
  output logic          mem_uns,
  output logic          ebreak
);

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
  localparam logic [6:0] OPC_OPW    = 7'b0111011;

  function automatic alu_op_e md_op(input logic [2:0] f3);
    case (f3)
      3'b000:  md_op = ALU_MUL;
      3'b001:  md_op = ALU_MULH;
      3'b010:  md_op = ALU_MULHSU;
      3'b011:  md_op = ALU_MULHU;
      3'b100:  md_op = ALU_DIV;
      3'b101:  md_op = ALU_DIVU;
      3'b110:  md_op = ALU_REM;
      default: md_op = ALU_REMU;
    endcase
  endfunction

  logic [6:0] opcode_s, funct7_s;
  logic [2:0] funct3_s;
  logic [4:0] rd_s;
  assign opcode_s = inst[6:0];
  assign funct3_s = inst[14:12];
  assign funct7_s = inst[31:25];
  assign rd_s     = inst[11:7];

  logic [DW-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  assign imm_i_s = {{52{inst[31]}}, inst[31:20]};
  assign imm_s_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b_s = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u_s = {{32{inst[31]}}, inst[31:12], 12'h000};
  assign imm_j_s = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  logic          legal_s, word_s, clr_lsb_s, is_br_s, jal_s, jalr_s, ebreak_s;
  logic          wb_load_s, wb_pc_s, wb_alu_s, ren_s, wen_s, uns_s;
  logic [1:0]    size_s;
  logic [DW-1:0] imm_sel_s, op_a_s, op_b_s;
  alu_op_e       alu_op_s;

  // Instruction decode: legality, operand selection and raw control bits.
  always_comb begin
    legal_s   = 1'b0;  word_s  = 1'b0;  clr_lsb_s = 1'b0;  is_br_s  = 1'b0;
    jal_s     = 1'b0;  jalr_s  = 1'b0;  ebreak_s  = 1'b0;
    wb_load_s = 1'b0;  wb_pc_s = 1'b0;  wb_alu_s  = 1'b0;
    ren_s     = 1'b0;  wen_s   = 1'b0;  uns_s     = 1'b0;  size_s = 2'b00;
    imm_sel_s = {DW{1'b0}};
    op_a_s    = rs1_data;
    op_b_s    = rs2_data;
    alu_op_s  = ALU_ADD;
    case (opcode_s)
      OPC_LUI: begin
        legal_s = 1'b1; imm_sel_s = imm_u_s; op_a_s = {DW{1'b0}}; op_b_s = imm_u_s; wb_alu_s = 1'b1;
      end
      OPC_AUIPC: begin
        legal_s = 1'b1; imm_sel_s = imm_u_s; op_a_s = pc; op_b_s = imm_u_s; wb_alu_s = 1'b1;
      end
      OPC_JAL: begin
        legal_s = 1'b1; imm_sel_s = imm_j_s; op_a_s = pc; op_b_s = imm_j_s;
        jal_s = 1'b1; wb_pc_s = 1'b1;
      end
      OPC_JALR: begin
        legal_s = (funct3_s == 3'b000); imm_sel_s = imm_i_s; op_b_s = imm_i_s;
        clr_lsb_s = 1'b1; jalr_s = 1'b1; wb_pc_s = 1'b1;
      end
      OPC_BRANCH: begin
        legal_s = (funct3_s[2:1] != 2'b01); imm_sel_s = imm_b_s;
        alu_op_s = ALU_SUB; is_br_s = 1'b1;
      end
      OPC_LOAD: begin
        legal_s = (funct3_s != 3'b111); imm_sel_s = imm_i_s; op_b_s = imm_i_s;
        ren_s = 1'b1; wb_load_s = 1'b1; size_s = funct3_s[1:0]; uns_s = funct3_s[2];
      end
      OPC_STORE: begin
        legal_s = ~funct3_s[2]; imm_sel_s = imm_s_s; op_b_s = imm_s_s;
        wen_s = 1'b1; size_s = funct3_s[1:0];
      end
      OPC_OPIMM: begin
        imm_sel_s = imm_i_s; op_b_s = imm_i_s; wb_alu_s = 1'b1; legal_s = 1'b1;
        case (funct3_s)
          3'b000:  alu_op_s = ALU_ADD;
          3'b001:  begin alu_op_s = ALU_SLL; legal_s = (inst[31:26] == 6'b000000); end
          3'b010:  alu_op_s = ALU_SLT;
          3'b011:  alu_op_s = ALU_SLTU;
          3'b100:  alu_op_s = ALU_XOR;
          3'b101:  begin
            alu_op_s = inst[30] ? ALU_SRA : ALU_SRL;
            legal_s  = ({inst[31], inst[29:26]} == 5'b00000);
          end
          3'b110:  alu_op_s = ALU_OR;
          default: alu_op_s = ALU_AND;
        endcase
      end
      OPC_OPIMMW: begin
        word_s = 1'b1; imm_sel_s = imm_i_s; op_b_s = imm_i_s; wb_alu_s = 1'b1;
        case (funct3_s)
          3'b000:  begin alu_op_s = ALU_ADD; legal_s = 1'b1; end
          3'b001:  begin alu_op_s = ALU_SLL; legal_s = (funct7_s == 7'b0000000); end
          3'b101:  begin
            alu_op_s = inst[30] ? ALU_SRA : ALU_SRL;
            legal_s  = ({funct7_s[6], funct7_s[4:0]} == 6'b000000);
          end
          default: legal_s = 1'b0;
        endcase
      end
      OPC_OP, OPC_OPW: begin
        word_s = (opcode_s == OPC_OPW); wb_alu_s = 1'b1;
        case (funct7_s)
          7'b0000000: begin
            legal_s = ~word_s | (funct3_s == 3'b000) | (funct3_s == 3'b001) | (funct3_s == 3'b101);
            case (funct3_s)
              3'b000:  alu_op_s = ALU_ADD;
              3'b001:  alu_op_s = ALU_SLL;
              3'b010:  alu_op_s = ALU_SLT;
              3'b011:  alu_op_s = ALU_SLTU;
              3'b100:  alu_op_s = ALU_XOR;
              3'b101:  alu_op_s = ALU_SRL;
              3'b110:  alu_op_s = ALU_OR;
              default: alu_op_s = ALU_AND;
            endcase
          end
          7'b0100000: begin
            legal_s  = (funct3_s == 3'b000) | (funct3_s == 3'b101);
            alu_op_s = funct3_s[2] ? ALU_SRA : ALU_SUB;
          end
          7'b0000001: begin
            legal_s  = ~word_s | (funct3_s == 3'b000) | funct3_s[2];
            alu_op_s = md_op(funct3_s);
          end
          default: legal_s = 1'b0;
        endcase
      end
      default: ebreak_s = (inst == 32'h0010_0073);
    endcase
  end

  // Shared datapath: shifts, multiplier and guarded dividers for 64- and 32-bit forms.
  logic [5:0]         sh_s;
  logic [31:0]        a32_s, b32_s, sra32_s;
  logic [DW-1:0]      sra64_s, div_b64_s;
  logic [31:0]        div_b32_s;
  logic               a_sgn_s, b_sgn_s, dz64_s, ov64_s, dz32_s, ov32_s;
  logic [2*DW-1:0]    ma_s, mb_s, prod_s;
  logic signed [63:0] sq64_s, sr64_s;
  logic signed [31:0] sq32_s, sr32_s;
  logic [DW-1:0]      uq64_s, ur64_s;
  logic [31:0]        uq32_s, ur32_s;

  assign a32_s     = op_a_s[31:0];
  assign b32_s     = op_b_s[31:0];
  assign sh_s      = word_s ? {1'b0, op_b_s[4:0]} : op_b_s[5:0];
  assign sra64_s   = $signed(op_a_s) >>> sh_s;
  assign sra32_s   = $signed(a32_s) >>> op_b_s[4:0];
  assign a_sgn_s   = (alu_op_s == ALU_MULH) | (alu_op_s == ALU_MULHSU);
  assign b_sgn_s   = (alu_op_s == ALU_MULH);
  assign ma_s      = {{DW{a_sgn_s & op_a_s[DW-1]}}, op_a_s};
  assign mb_s      = {{DW{b_sgn_s & op_b_s[DW-1]}}, op_b_s};
  assign prod_s    = ma_s * mb_s;
  assign dz64_s    = (op_b_s == {DW{1'b0}});
  assign ov64_s    = (op_a_s == {1'b1, {(DW-1){1'b0}}}) & (op_b_s == {DW{1'b1}});
  assign dz32_s    = (b32_s == 32'h0000_0000);
  assign ov32_s    = (a32_s == 32'h8000_0000) & (b32_s == 32'hFFFF_FFFF);
  // A divisor of one on the special cases keeps the divider defined; results are overridden below.
  assign div_b64_s = (dz64_s | ov64_s) ? {{(DW-1){1'b0}}, 1'b1} : op_b_s;
  assign div_b32_s = (dz32_s | ov32_s) ? 32'h0000_0001 : b32_s;
  assign sq64_s    = $signed(op_a_s) / $signed(div_b64_s);
  assign sr64_s    = $signed(op_a_s) % $signed(div_b64_s);
  assign uq64_s    = op_a_s / div_b64_s;
  assign ur64_s    = op_a_s % div_b64_s;
  assign sq32_s    = $signed(a32_s) / $signed(div_b32_s);
  assign sr32_s    = $signed(a32_s) % $signed(div_b32_s);
  assign uq32_s    = a32_s / div_b32_s;
  assign ur32_s    = a32_s % div_b32_s;

  logic [DW-1:0] r64_s, alu_res_s;
  logic [31:0]   r32_s;

  // Result selection for the full-width operations.
  always_comb begin
    r64_s = {DW{1'b0}};
    case (alu_op_s)
      ALU_ADD:    r64_s = op_a_s + op_b_s;
      ALU_SUB:    r64_s = op_a_s - op_b_s;
      ALU_SLL:    r64_s = op_a_s << sh_s;
      ALU_SLT:    r64_s = {63'd0, $signed(op_a_s) < $signed(op_b_s)};
      ALU_SLTU:   r64_s = {63'd0, op_a_s < op_b_s};
      ALU_XOR:    r64_s = op_a_s ^ op_b_s;
      ALU_SRL:    r64_s = op_a_s >> sh_s;
      ALU_SRA:    r64_s = sra64_s;
      ALU_OR:     r64_s = op_a_s | op_b_s;
      ALU_AND:    r64_s = op_a_s & op_b_s;
      ALU_MUL:    r64_s = prod_s[DW-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  r64_s = prod_s[2*DW-1:DW];
      ALU_DIV:    r64_s = dz64_s ? {DW{1'b1}} : (ov64_s ? op_a_s : sq64_s);
      ALU_DIVU:   r64_s = dz64_s ? {DW{1'b1}} : uq64_s;
      ALU_REM:    r64_s = dz64_s ? op_a_s : (ov64_s ? {DW{1'b0}} : sr64_s);
      ALU_REMU:   r64_s = dz64_s ? op_a_s : ur64_s;
      default:    r64_s = {DW{1'b0}};
    endcase
  end

  // Result selection for the 32-bit word forms, before sign extension.
  always_comb begin
    r32_s = 32'h0000_0000;
    case (alu_op_s)
      ALU_ADD:  r32_s = a32_s + b32_s;
      ALU_SUB:  r32_s = a32_s - b32_s;
      ALU_SLL:  r32_s = a32_s << op_b_s[4:0];
      ALU_SRL:  r32_s = a32_s >> op_b_s[4:0];
      ALU_SRA:  r32_s = sra32_s;
      ALU_MUL:  r32_s = prod_s[31:0];
      ALU_DIV:  r32_s = dz32_s ? 32'hFFFF_FFFF : (ov32_s ? a32_s : sq32_s);
      ALU_DIVU: r32_s = dz32_s ? 32'hFFFF_FFFF : uq32_s;
      ALU_REM:  r32_s = dz32_s ? a32_s : (ov32_s ? 32'h0000_0000 : sr32_s);
      ALU_REMU: r32_s = dz32_s ? a32_s : ur32_s;
      default:  r32_s = 32'h0000_0000;
    endcase
  end

  assign alu_res_s = (word_s ? {{32{r32_s[31]}}, r32_s} : r64_s) & {{(DW-1){1'b1}}, ~clr_lsb_s};

  logic          br_cond_s;
  logic [DW-1:0] imm_d, result_d, imm_q, result_q;
  logic          zero_d, br_taken_d, jal_d, jalr_d, wb_en_d, wb_load_d, wb_pc_d, wb_alu_d;
  logic          zero_q, br_taken_q, jal_q, jalr_q, wb_en_q, wb_load_q, wb_pc_q, wb_alu_q;
  logic          mem_ren_d, mem_wen_d, mem_uns_d, ebreak_d;
  logic          mem_ren_q, mem_wen_q, mem_uns_q, ebreak_q;
  logic [1:0]    mem_size_d, mem_size_q;

  // Branch condition on the raw register operands.
  always_comb begin
    br_cond_s = 1'b0;
    case (funct3_s)
      3'b000:  br_cond_s = (rs1_data == rs2_data);
      3'b001:  br_cond_s = (rs1_data != rs2_data);
      3'b100:  br_cond_s = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  br_cond_s = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  br_cond_s = (rs1_data <  rs2_data);
      3'b111:  br_cond_s = (rs1_data >= rs2_data);
      default: br_cond_s = 1'b0;
    endcase
  end

  // Illegal encodings collapse to all-zero outputs; write-back sources stay one-hot with wb_en.
  always_comb begin
    result_d   = legal_s ? alu_res_s : {DW{1'b0}};
    imm_d      = legal_s ? imm_sel_s : {DW{1'b0}};
    zero_d     = (result_d == {DW{1'b0}});
    br_taken_d = legal_s & is_br_s & br_cond_s;
    jal_d      = legal_s & jal_s;
    jalr_d     = legal_s & jalr_s;
    wb_en_d    = legal_s & (wb_load_s | wb_pc_s | wb_alu_s) & (rd_s != 5'd0);
    wb_load_d  = wb_en_d & wb_load_s;
    wb_pc_d    = wb_en_d & wb_pc_s;
    wb_alu_d   = wb_en_d & wb_alu_s;
    mem_ren_d  = legal_s & ren_s;
    mem_wen_d  = legal_s & wen_s;
    mem_size_d = (legal_s & (ren_s | wen_s)) ? size_s : 2'b00;
    mem_uns_d  = legal_s & ren_s & uns_s;
    ebreak_d   = ebreak_s;
  end

  // Output register stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      imm_q <= {DW{1'b0}}; result_q <= {DW{1'b0}}; zero_q <= 1'b0; br_taken_q <= 1'b0;
      jal_q <= 1'b0; jalr_q <= 1'b0; wb_en_q <= 1'b0; wb_load_q <= 1'b0; wb_pc_q <= 1'b0;
      wb_alu_q <= 1'b0; mem_ren_q <= 1'b0; mem_wen_q <= 1'b0; mem_size_q <= 2'b00;
      mem_uns_q <= 1'b0; ebreak_q <= 1'b0;
    end else begin
      imm_q <= imm_d; result_q <= result_d; zero_q <= zero_d; br_taken_q <= br_taken_d;
      jal_q <= jal_d; jalr_q <= jalr_d; wb_en_q <= wb_en_d; wb_load_q <= wb_load_d;
      wb_pc_q <= wb_pc_d; wb_alu_q <= wb_alu_d; mem_ren_q <= mem_ren_d;
      mem_wen_q <= mem_wen_d; mem_size_q <= mem_size_d; mem_uns_q <= mem_uns_d;
      ebreak_q <= ebreak_d;
    end
  end

  assign imm      = imm_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign br_taken = br_taken_q;
  assign jal_en   = jal_q;
  assign jalr_en  = jalr_q;
  assign wb_en    = wb_en_q;
  assign wb_load  = wb_load_q;
  assign wb_pc    = wb_pc_q;
  assign wb_alu   = wb_alu_q;
  assign mem_ren  = mem_ren_q;
  assign mem_wen  = mem_wen_q;
  assign mem_size = mem_size_q;
  assign mem_uns  = mem_uns_q;
  assign ebreak   = ebreak_q;

endmodule

// File: tb/tb_rv64_decode_exec.sv
// Directed self-checking bench for rv64_decode_exec with hand-encoded instructions
// and hand-computed expected results.
module tb_rv64_decode_exec;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] inst;
  logic [63:0] pc, rs1_data, rs2_data;
  logic [63:0] imm, result;
  logic        zero, br_taken, jal_en, jalr_en, wb_en, wb_load, wb_pc, wb_alu;
  logic        mem_ren, mem_wen, mem_uns, ebreak;
  logic [1:0]  mem_size;
  logic [13:0] ctrl;

  int checks = 0;
  int errors = 0;

  rv64_decode_exec #(.DW(64), .IW(32)) dut (
    .clk(clk), .rstn(rstn), .inst(inst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .result(result), .zero(zero), .br_taken(br_taken), .jal_en(jal_en),
    .jalr_en(jalr_en), .wb_en(wb_en), .wb_load(wb_load), .wb_pc(wb_pc), .wb_alu(wb_alu),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_size(mem_size), .mem_uns(mem_uns),
    .ebreak(ebreak)
  );

  always #5 clk = ~clk;

  // {zero, br, jal, jalr}_{wb_en, load, pc, alu}_{ren, wen}_{size}_{uns, ebreak}
  assign ctrl = {zero, br_taken, jal_en, jalr_en, wb_en, wb_load, wb_pc, wb_alu,
                 mem_ren, mem_wen, mem_size, mem_uns, ebreak};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] i, input logic [63:0] p, input logic [63:0] a,
                      input logic [63:0] b);
    @(negedge clk);
    inst = i; pc = p; rs1_data = a; rs2_data = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; inst = 32'hFFF0_0093; pc = 64'h0; rs1_data = 64'h0; rs2_data = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 64'h0);
    chk("rst_imm", imm, 64'h0);
    chk("rst_ctrl", {50'h0, ctrl}, {50'h0, 14'b0});

    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    chk("addi_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_ctl", {50'h0, ctrl}, {50'h0, 14'b0000_1001_00_00_00});

    step(32'h0020_81BB, 64'h0, 64'h7FFF_FFFF, 64'h1);                 // ADDW
    chk("addw_res", result, 64'hFFFF_FFFF_8000_0000);
    chk("addw_imm", imm, 64'h0);
    chk("addw_ctl", {50'h0, ctrl}, {50'h0, 14'b0000_1001_00_00_00});
    step(32'h4020_D1BB, 64'h0, 64'h8000_0000, 64'h4);                 // SRAW
    chk("sraw_res", result, 64'hFFFF_FFFF_F800_0000);
    step(32'h0010_819B, 64'h0, 64'h7FFF_FFFF, 64'h0);                 // ADDIW +1
    chk("addiw_res", result, 64'hFFFF_FFFF_8000_0000);
    chk("addiw_imm", imm, 64'h1);
    step(32'h0020_91BB, 64'h0, 64'h1, 64'd33);                        // SLLW uses shamt[4:0]
    chk("sllw_res", result, 64'h2);
    step(32'h43F0_D193, 64'h0, 64'h8000_0000_0000_0000, 64'h0);       // SRAI 63
    chk("srai_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("srai_imm", imm, 64'h43F);
    step(32'h0020_A1B3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);       // SLT
    chk("slt_res", result, 64'h1);

    step(32'h0220_C1B3, 64'h0, 64'h5, 64'h0);                         // DIV by zero
    chk("div0_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
    step(32'h0220_C1B3, 64'h0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("div_ovf_res", result, 64'h8000_0000_0000_0000);
    step(32'h0220_E1B3, 64'h0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rem_ovf_res", result, 64'h0);
    chk("rem_ovf_ctl", {50'h0, ctrl}, {50'h0, 14'b1000_1001_00_00_00});
    step(32'h0220_B1B3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mulhu_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
    step(32'h0220_91B3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mulh_res", result, 64'h0);
    step(32'h0220_D1B3, 64'h0, 64'h7, 64'h0);                         // DIVU by zero
    chk("divu0_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
    step(32'h0220_F1B3, 64'h0, 64'h7, 64'h0);                         // REMU by zero
    chk("remu0_res", result, 64'h7);
    step(32'h0220_E1BB, 64'h0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2);       // REMW -7 % 2
    chk("remw_res", result, 64'hFFFF_FFFF_FFFF_FFFF);

    step(32'h0020_C463, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);       // BLT
    chk("blt_ctl", {50'h0, ctrl}, {50'h0, 14'b0100_0000_00_00_00});
    chk("blt_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("blt_imm", imm, 64'h8);
    step(32'h0020_E463, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);       // BLTU
    chk("bltu_ctl", {50'h0, ctrl}, {50'h0, 14'b0000_0000_00_00_00});
    step(32'h0020_8463, 64'h0, 64'h1234, 64'h1234);                   // BEQ
    chk("beq_ctl", {50'h0, ctrl}, {50'h0, 14'b1100_0000_00_00_00});
    step(32'h0020_D463, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);       // BGE
    chk("bge_br", {63'h0, br_taken}, 64'h0);

    step(32'h0040_80E7, 64'h0, 64'h8000_0003, 64'h0);                 // JALR 4(x1)
    chk("jalr_res", result, 64'h8000_0006);
    chk("jalr_ctl", {50'h0, ctrl}, {50'h0, 14'b0001_1010_00_00_00});
    step(32'hFF9F_F0EF, 64'h8000_0000, 64'h0, 64'h0);                 // JAL -8
    chk("jal_res", result, 64'h7FFF_FFF8);
    chk("jal_imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("jal_ctl", {50'h0, ctrl}, {50'h0, 14'b0010_1010_00_00_00});

    step(32'h0080_E183, 64'h0, 64'h1000, 64'h0);                      // LWU 8(x1)
    chk("lwu_res", result, 64'h1008);
    chk("lwu_ctl", {50'h0, ctrl}, {50'h0, 14'b0000_1100_10_10_10});
    step(32'h0020_B823, 64'h0, 64'h2000, 64'h55);                     // SD 16(x1)
    chk("sd_res", result, 64'h2010);
    chk("sd_imm", imm, 64'h10);
    chk("sd_ctl", {50'h0, ctrl}, {50'h0, 14'b0000_0000_01_11_00});
    step(32'hFE20_8FA3, 64'h0, 64'h2000, 64'h55);                     // SB -1(x1)
    chk("sb_res", result, 64'h1FFF);
    chk("sb_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sb_ctl", {50'h0, ctrl}, {50'h0, 14'b0000_0000_01_00_00});
    step(32'h0010_0073, 64'h0, 64'h0, 64'h0);                         // EBREAK
    chk("ebreak_ctl", {51'h0, ctrl[12:0]}, {51'h0, 13'b000_0000_00_00_01});
    chk("ebreak_res", result, 64'h0);
    step(32'h0050_0013, 64'h0, 64'h0, 64'h0);                         // ADDI x0,x0,5
    chk("addi_x0_res", result, 64'h5);
    chk("addi_x0_ctl", {50'h0, ctrl}, {50'h0, 14'b0000_0000_00_00_00});
    step(32'hFFFF_FFFF, 64'h0, 64'h77, 64'h88);                       // illegal
    chk("illegal_ctl", {51'h0, ctrl[12:0]}, {51'h0, 13'b0});
    chk("illegal_res", result, 64'h0);
    chk("illegal_imm", imm, 64'h0);
    step(32'h8000_02B7, 64'h0, 64'h0, 64'h0);                         // LUI
    chk("lui_res", result, 64'hFFFF_FFFF_8000_0000);
    chk("lui_ctl", {50'h0, ctrl}, {50'h0, 14'b0000_1001_00_00_00});
    step(32'h0000_1297, 64'h1000, 64'h0, 64'h0);                      // AUIPC
    chk("auipc_res", result, 64'h2000);

    #1 rstn = 1'b0;                                                   // asynchronous clear
    #1;
    chk("async_rst_res", result, 64'h0);
    chk("async_rst_ctl", {50'h0, ctrl}, {50'h0, 14'b0});
    @(negedge clk);
    inst = 32'hFFF0_0093; rs1_data = 64'h0; rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("post_rst_ctl", {50'h0, ctrl}, {50'h0, 14'b0000_1001_00_00_00});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
